track_scan_sequencer: RTL and testbench

//  Sequences one multi-track scan around track_zero_trigger: drives its pmt_start_en, waits out
//  its 4-cycle arm pipeline, counts per-revolution track triggers up to a programmed track count,

---
 rtl/track_scan_sequencer_if.sv | 34 +++
 rtl/track_scan_sequencer.sv | 171 +++++++++++++++++
 tb/tb_track_scan_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/track_scan_sequencer_if.sv
// Host, trigger and status signals of track_scan_sequencer; slave = sequencer, master = host/trigger side.
// Pure wiring bundle, no logic.
interface track_scan_sequencer_if #(
  parameter int TRK_W = 32
);
  logic             scan_start_i;
  logic             scan_abort_i;
  logic [TRK_W-1:0] cfg_track_num_i;
  logic [31:0]      cfg_timeout_i;
  logic             track_trigger_i;
  logic [TRK_W-1:0] track_index_i;
  logic             pmt_start_en_o;
  logic             scan_busy_o;
  logic             track_valid_o;
  logic [TRK_W-1:0] track_cnt_o;
  logic             scan_done_o;
  logic             scan_err_o;
  logic [1:0]       err_code_o;
  logic [2:0]       state_o;

  modport slave (
    input  scan_start_i, scan_abort_i, cfg_track_num_i, cfg_timeout_i,
           track_trigger_i, track_index_i,
    output pmt_start_en_o, scan_busy_o, track_valid_o, track_cnt_o,
           scan_done_o, scan_err_o, err_code_o, state_o
  );

  modport master (
    output scan_start_i, scan_abort_i, cfg_track_num_i, cfg_timeout_i,
           track_trigger_i, track_index_i,
    input  pmt_start_en_o, scan_busy_o, track_valid_o, track_cnt_o,
           scan_done_o, scan_err_o, err_code_o, state_o
  );
endinterface

// File: rtl/track_scan_sequencer.sv
// Sequences one multi-track scan around track_zero_trigger (arm, count triggers, guard gap, done).
// Outputs registered, 1-cycle response, no backpressure; SCAN_TIMEOUT_EN adds an inter-trigger watchdog.
module track_scan_sequencer #(
  parameter int TRK_W     = 32,
  parameter int ARM_CYC   = 4,
  parameter int GUARD_CYC = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  track_scan_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_GUARD = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] ARM_LAST   = 8'(ARM_CYC - 1);
  localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYC - 1);

  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_MISMATCH = 2'd2;
  localparam logic [1:0] ERR_ABORT    = 2'd3;

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  state_t           r_state, w_state_nxt;
  logic [7:0]       r_phase, w_phase_nxt;
  logic [TRK_W-1:0] r_track_cnt, w_cnt_nxt, w_cnt_inc;
  logic [TRK_W-1:0] r_track_num, w_num_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_err, w_err_nxt;
  logic [1:0]       r_code, w_code_nxt;
  logic             w_err_hit;
  logic [1:0]       w_code_hit;
  logic             r_en, r_busy, r_done;
`ifdef SCAN_TIMEOUT_EN
  logic [31:0]      r_timeout, w_timeout_nxt;
  logic [31:0]      r_wdog, w_wdog_nxt;
`else
  logic             w_unused_timeout;
  assign w_unused_timeout = ^bus.cfg_timeout_i;
`endif

  // Reset asserts asynchronously but releases two clocks later, in step with clk_i.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_track_cnt <= '0;
      r_track_num <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_code      <= 2'd0;
      r_en        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef SCAN_TIMEOUT_EN
      r_timeout   <= '0;
      r_wdog      <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_track_cnt <= w_cnt_nxt;
      r_track_num <= w_num_nxt;
      r_valid     <= w_valid_nxt;
      r_err       <= w_err_nxt;
      r_code      <= w_code_nxt;
      r_en        <= (w_state_nxt == S_ARM) || (w_state_nxt == S_RUN);
      r_busy      <= (w_state_nxt == S_ARM) || (w_state_nxt == S_RUN) || (w_state_nxt == S_GUARD);
      r_done      <= (w_state_nxt == S_DONE);
`ifdef SCAN_TIMEOUT_EN
      r_timeout   <= w_timeout_nxt;
      r_wdog      <= w_wdog_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_track_cnt;
    w_num_nxt   = r_track_num;
    w_valid_nxt = 1'b0;
    w_err_nxt   = r_err;
    w_code_nxt  = r_code;
    w_err_hit   = 1'b0;
    w_code_hit  = 2'd0;
    w_cnt_inc   = (&r_track_cnt) ? r_track_cnt : r_track_cnt + TRK_W'(1);
`ifdef SCAN_TIMEOUT_EN
    w_timeout_nxt = r_timeout;
    w_wdog_nxt    = '0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.scan_start_i) begin
          w_state_nxt = S_ARM;
          w_num_nxt   = bus.cfg_track_num_i;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b0;
          w_code_nxt  = 2'd0;
`ifdef SCAN_TIMEOUT_EN
          w_timeout_nxt = bus.cfg_timeout_i;
`endif
        end
      end
      S_ARM: begin
        if (bus.scan_abort_i) begin
          w_err_hit  = 1'b1;
          w_code_hit = ERR_ABORT;
        end else if (r_phase == ARM_LAST) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // A trigger is always counted; mismatch, abort and timeout then rank in that order.
        if (bus.track_trigger_i) begin
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = w_cnt_inc;
          if (bus.track_index_i != r_track_cnt) begin
            w_err_hit  = 1'b1;
            w_code_hit = ERR_MISMATCH;
          end else if ((r_track_num != '0) && (w_cnt_inc == r_track_num)) begin
            w_state_nxt = S_GUARD;
          end
        end
        if (!w_err_hit && bus.scan_abort_i) begin
          w_err_hit  = 1'b1;
          w_code_hit = ERR_ABORT;
        end
`ifdef SCAN_TIMEOUT_EN
        if (!bus.track_trigger_i) begin
          w_wdog_nxt = r_wdog + 32'd1;
          if (!w_err_hit && (r_timeout != '0) && (r_wdog == r_timeout - 32'd1)) begin
            w_err_hit  = 1'b1;
            w_code_hit = ERR_TIMEOUT;
          end
        end
`endif
      end
      S_GUARD: begin
        if (r_phase == GUARD_LAST) w_state_nxt = r_err ? S_IDLE : S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_err_hit) begin
      w_state_nxt = S_GUARD;
      w_err_nxt   = 1'b1;
      if (!r_err) w_code_nxt = w_code_hit;
    end
    w_phase_nxt = (w_state_nxt != r_state) ? 8'd0 : r_phase + 8'd1;
  end

  assign bus.pmt_start_en_o = r_en;
  assign bus.scan_busy_o    = r_busy;
  assign bus.track_valid_o  = r_valid;
  assign bus.track_cnt_o    = r_track_cnt;
  assign bus.scan_done_o    = r_done;
  assign bus.scan_err_o     = r_err;
  assign bus.err_code_o     = r_code;
  assign bus.state_o        = r_state;
endmodule

// File: tb/tb_track_scan_sequencer.sv
// Directed bench for track_scan_sequencer; accepted-trigger counts are scoreboarded through a queue.
module tb_track_scan_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] exp_q[$];

  track_scan_sequencer_if #(.TRK_W(32)) bus();

  track_scan_sequencer #(.TRK_W(32), .ARM_CYC(4), .GUARD_CYC(8)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input logic [31:0] num, input logic [31:0] tmo);
    bus.cfg_track_num_i = num;
    bus.cfg_timeout_i   = tmo;
    bus.scan_start_i    = 1'b1;
    tick(1);
    bus.scan_start_i    = 1'b0;
  endtask

  task automatic trig(input logic [31:0] idx, input logic [31:0] exp_cnt);
    bus.track_trigger_i = 1'b1;
    bus.track_index_i   = idx;
    exp_q.push_back(exp_cnt);
    tick(1);
    bus.track_trigger_i = 1'b0;
    bus.track_index_i   = '0;
  endtask

  // Scoreboard: every track_valid pulse must match the next expected count.
  always @(posedge clk) begin
    logic [31:0] e;
    #2;
    if (bus.track_valid_o === 1'b1) begin
      chk("valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("track_cnt_sb", bus.track_cnt_o, e);
      end
    end
  end

  initial begin
    bus.scan_start_i    = 1'b0;
    bus.scan_abort_i    = 1'b0;
    bus.cfg_track_num_i = '0;
    bus.cfg_timeout_i   = '0;
    bus.track_trigger_i = 1'b0;
    bus.track_index_i   = '0;
    #2 rst_n = 1'b0;
    tick(3);
    chk("rst_state", bus.state_o, 0);
    chk("rst_en", bus.pmt_start_en_o, 0);
    chk("rst_busy", bus.scan_busy_o, 0);
    chk("rst_cnt", bus.track_cnt_o, 0);
    chk("rst_err", bus.scan_err_o, 0);
    rst_n = 1'b1;
    tick(3);

    // 1: three-track normal scan
    start_scan(3, 0);
    chk("t1_arm_state", bus.state_o, 1);
    chk("t1_arm_en", bus.pmt_start_en_o, 1);
    chk("t1_arm_busy", bus.scan_busy_o, 1);
    tick(3);
    chk("t1_arm_last", bus.state_o, 1);
    tick(1);
    chk("t1_run_state", bus.state_o, 2);
    trig(0, 1);
    tick(99);
    trig(1, 2);
    tick(99);
    trig(2, 3);
    chk("t1_guard_cnt", bus.track_cnt_o, 3);
    for (int i = 0; i < 8; i++) begin
      chk("t1_guard_state", bus.state_o, 3);
      chk("t1_guard_en", bus.pmt_start_en_o, 0);
      tick(1);
    end
    chk("t1_done_state", bus.state_o, 4);
    chk("t1_done_pulse", bus.scan_done_o, 1);
    chk("t1_err", bus.scan_err_o, 0);
    tick(1);
    chk("t1_idle_state", bus.state_o, 0);
    chk("t1_done_low", bus.scan_done_o, 0);
    chk("t1_busy_low", bus.scan_busy_o, 0);

    // 2: trigger during ARM is ignored
    start_scan(1, 0);
    tick(1);
    bus.track_trigger_i = 1'b1;
    tick(1);
    bus.track_trigger_i = 1'b0;
    tick(2);
    chk("t2_run_state", bus.state_o, 2);
    chk("t2_cnt_arm", bus.track_cnt_o, 0);
    trig(0, 1);
    chk("t2_cnt_run", bus.track_cnt_o, 1);
    tick(8);
    chk("t2_done", bus.scan_done_o, 1);
    tick(1);

    // 3: abort after two triggers
    start_scan(5, 0);
    tick(4);
    trig(0, 1);
    tick(2);
    trig(1, 2);
    tick(2);
    bus.scan_abort_i = 1'b1;
    tick(1);
    bus.scan_abort_i = 1'b0;
    chk("t3_state", bus.state_o, 3);
    chk("t3_err", bus.scan_err_o, 1);
    chk("t3_code", bus.err_code_o, 3);
    chk("t3_en", bus.pmt_start_en_o, 0);
    chk("t3_cnt", bus.track_cnt_o, 2);
    tick(8);
    chk("t3_idle", bus.state_o, 0);
    chk("t3_no_done", bus.scan_done_o, 0);
    chk("t3_err_sticky", bus.scan_err_o, 1);

    // simultaneous trigger and abort: trigger counted, abort wins
    start_scan(5, 0);
    chk("t7_err_clr", bus.scan_err_o, 0);
    chk("t7_code_clr", bus.err_code_o, 0);
    tick(4);
    bus.scan_abort_i = 1'b1;
    trig(0, 1);
    bus.scan_abort_i = 1'b0;
    chk("t7_cnt", bus.track_cnt_o, 1);
    chk("t7_state", bus.state_o, 3);
    chk("t7_code", bus.err_code_o, 3);
    tick(9);

    // 5: index mismatch, then restart clears the error
    start_scan(3, 0);
    tick(4);
    trig(1, 1);
    chk("t5_en", bus.pmt_start_en_o, 0);
    chk("t5_state", bus.state_o, 3);
    chk("t5_code", bus.err_code_o, 2);
    chk("t5_err", bus.scan_err_o, 1);
    tick(9);
    chk("t5_idle", bus.state_o, 0);
    chk("t5_code_hold", bus.err_code_o, 2);
    start_scan(1, 0);
    chk("t5_err_clr", bus.scan_err_o, 0);
    chk("t5_code_clr", bus.err_code_o, 0);
    tick(4);
    trig(0, 1);
    tick(8);
    chk("t5_done", bus.scan_done_o, 1);
    tick(1);

    // 4: watchdog
    start_scan(0, 50);
    tick(4);
    chk("t4_run", bus.state_o, 2);
`ifdef SCAN_TIMEOUT_EN
    tick(49);
    chk("t4_before_state", bus.state_o, 2);
    chk("t4_before_err", bus.scan_err_o, 0);
    tick(1);
    chk("t4_to_state", bus.state_o, 3);
    chk("t4_to_err", bus.scan_err_o, 1);
    chk("t4_to_code", bus.err_code_o, 1);
    chk("t4_to_en", bus.pmt_start_en_o, 0);
`else
    tick(60);
    chk("t4_stay_state", bus.state_o, 2);
    chk("t4_stay_err", bus.scan_err_o, 0);
    chk("t4_stay_en", bus.pmt_start_en_o, 1);
    bus.scan_abort_i = 1'b1;
    tick(1);
    bus.scan_abort_i = 1'b0;
    chk("t4_abort_code", bus.err_code_o, 3);
`endif
    tick(9);
    chk("t4_idle", bus.state_o, 0);

    // 6: reset mid-RUN, then a normal scan
    start_scan(0, 0);
    tick(4);
    trig(0, 1);
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("t6_state", bus.state_o, 0);
    chk("t6_en", bus.pmt_start_en_o, 0);
    chk("t6_busy", bus.scan_busy_o, 0);
    chk("t6_cnt", bus.track_cnt_o, 0);
    chk("t6_valid", bus.track_valid_o, 0);
    chk("t6_err", bus.scan_err_o, 0);
    chk("t6_code", bus.err_code_o, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    start_scan(2, 0);
    tick(4);
    trig(0, 1);
    tick(5);
    trig(1, 2);
    tick(8);
    chk("t6_done", bus.scan_done_o, 1);
    chk("t6_done_err", bus.scan_err_o, 0);
    tick(2);

    chk("sb_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
